// File: rtl/pattern_scan_pkg.sv
// Shared types for the pattern scan controller.
// Holds the FSM state encoding and the default detector pattern.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_scan_if.sv
// Word handshake between a producer and the scan controller.
// The producer drives the master side; the controller is the slave.
interface pattern_scan_if #(
    parameter int WORD_W = 8
);
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/pattern_scan_ctrl_core.sv
// Overlapping serial pattern matcher with bit history.
// The fill counter blocks matches until PAT_W bits have arrived.
module pattern_match_core
    import pattern_scan_pkg::*;
#(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic match
);
    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);

    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;

    // The newest bit joins the stored history for the compare.
    assign match = bit_valid
                && (fill == FULL)
                && ({hist, bit_in} == PATTERN);

    // Shift in accepted bits and count how many are held.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_valid) begin
            hist <= (PAT_W-1)'({hist, bit_in});
            if (fill != FULL) begin
                fill <= fill + FW'(1);
            end
        end
    end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame controller: loads words, serializes them MSB-first
// into the matcher and totals matches per frame.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int               WORD_W      = 8,
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PATTERN     = DEF_PATTERN,
    parameter int               FRAME_WORDS = 4,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    pattern_scan_if.slave    src,
    output logic             bit_valid,
    output logic             bit_out,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic             done
);
    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [IW-1:0]    LAST_BIT  = IW'(WORD_W - 1);
    localparam logic [WW-1:0]    LAST_WORD = WW'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [WW-1:0]     wcnt;
    logic [WORD_W-1:0] sreg;
    logic              ready_q;
    logic              match;
    logic              clr;

    assign clr = (state == IDLE) && start;
    assign src.word_ready = ready_q;
    assign bit_out = sreg[WORD_W-1];

    pattern_match_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .bit_valid (bit_valid),
        .bit_in    (bit_out),
        .match     (match)
    );

    // Frame sequencing, registered outputs and match accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            wcnt        <= '0;
            sreg        <= '0;
            busy        <= 1'b0;
            ready_q     <= 1'b0;
            bit_valid   <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            match_pulse <= match;
            done        <= 1'b0;
            if (match) begin
                if (match_count == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    match_count <= match_count + CNT_W'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        busy        <= 1'b1;
                        ready_q     <= 1'b1;
                        wcnt        <= '0;
                        match_count <= '0;
                        overflow    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (src.word_valid) begin
                        state     <= SHIFT;
                        ready_q   <= 1'b0;
                        bit_valid <= 1'b1;
                        sreg      <= src.word_data;
                        idx       <= LAST_BIT;
                    end
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    idx  <= idx - IW'(1);
                    if (idx == '0) begin
                        bit_valid <= 1'b0;
                        if (wcnt == LAST_WORD) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            wcnt    <= wcnt + WW'(1);
                            state   <= LOAD;
                            ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl.
// Two DUTs (CNT_W 8 and 2) share one stimulus stream.
module tb_pattern_scan_ctrl;

    typedef struct {
        int cnt;
        int ovf;
        int pulses;
        int off;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic       busy1, bv1, bo1, mp1, ovf1, done1;
    logic [7:0] cnt1;
    logic       busy2, bv2, bo2, mp2, ovf2, done2;
    logic [1:0] cnt2;

    int n_vec = 0;
    int n_bad = 0;
    exp_t q1[$];
    exp_t q2[$];

    pattern_scan_if #(.WORD_W(8)) bus1 ();
    pattern_scan_if #(.WORD_W(8)) bus2 ();

    assign bus2.word_valid = bus1.word_valid;
    assign bus2.word_data  = bus1.word_data;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.CNT_W(8)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy1),
        .src         (bus1.slave),
        .bit_valid   (bv1),
        .bit_out     (bo1),
        .match_pulse (mp1),
        .match_count (cnt1),
        .overflow    (ovf1),
        .done        (done1)
    );

    pattern_scan_ctrl #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy2),
        .src         (bus2.slave),
        .bit_valid   (bv2),
        .bit_out     (bo2),
        .match_pulse (mp2),
        .match_count (cnt2),
        .overflow    (ovf2),
        .done        (done2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d",
                     name, $time, act, exp);
        end
    endtask

    // Monitor for the wide-counter DUT.
    int  off1 = 0, pls1 = 0, run1 = 0;
    logic busy1_d = 1'b0, done1_d = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy1 && !busy1_d) begin
            off1 = 0;
            pls1 = 0;
        end else if (busy1) begin
            off1++;
        end
        pls1 += int'(mp1);
        if (bv1) begin
            run1++;
        end else begin
            if (run1 != 0 && busy1) chk("shift_run", run1, 8);
            run1 = 0;
        end
        if (done1) begin
            chk("done_len", int'(done1_d), 0);
            if (q1.size() == 0) begin
                chk("sb1_empty", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("cnt1", int'(cnt1), e.cnt);
                chk("ovf1", int'(ovf1), e.ovf);
                chk("pulses1", pls1, e.pulses);
                chk("done_off", off1, e.off);
            end
        end
        busy1_d = busy1;
        done1_d = done1;
    end

    // Monitor for the saturating 2-bit DUT.
    int  pls2 = 0;
    logic busy2_d = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy2 && !busy2_d) pls2 = 0;
        pls2 += int'(mp2);
        if (done2) begin
            if (q2.size() == 0) begin
                chk("sb2_empty", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("cnt2", int'(cnt2), e.cnt);
                chk("ovf2", int'(ovf2), e.ovf);
                chk("pulses2", pls2, e.pulses);
            end
        end
        busy2_d = busy2;
    end

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.word_ready && n < 200);
        if (!bus1.word_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done1 && n < 200);
        if (!done1) chk("done_timeout", 0, 1);
    endtask

    task automatic reset_outs(input string tag);
        chk({tag, "_outs1"},
            int'({busy1, bus1.word_ready, bv1, bo1, mp1,
                  done1, ovf1, cnt1}), 0);
        chk({tag, "_outs2"},
            int'({busy2, bus2.word_ready, bv2, bo2, mp2,
                  done2, ovf2, cnt2}), 0);
    endtask

    task automatic frame(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3,
                         input int stall, input int pulses,
                         input int off, input bit poke);
        logic [7:0] w[4];
        exp_t e;
        w = '{w0, w1, w2, w3};
        e = '{cnt: pulses, ovf: 0, pulses: pulses, off: off};
        q1.push_back(e);
        e.cnt = (pulses > 3) ? 3 : pulses;
        e.ovf = (pulses > 3) ? 1 : 0;
        q2.push_back(e);
        @(posedge clk); #1;
        start = 1'b1;
        bus1.word_valid = 1'b1;
        bus1.word_data = w[0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            if (i == 0) begin
                chk("clr_cnt1", int'(cnt1), 0);
                chk("clr_ovf1", int'(ovf1), 0);
                chk("clr_cnt2", int'(cnt2), 0);
                chk("clr_ovf2", int'(ovf2), 0);
            end
            if (i == 1 && stall > 0) begin
                repeat (stall) @(posedge clk);
                #1 bus1.word_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus1.word_data = (i < 3) ? w[i+1] : 8'hFF;
            bus1.word_valid = !(i == 0 && stall > 0);
            if (poke && i == 0) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_done();
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("start_in_done", int'(busy1), 0);
        end
        bus1.word_valid = 1'b0;
    endtask

    initial begin
        bus1.word_valid = 1'b0;
        bus1.word_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset_outs("reset");

        frame(8'h0B, 8'h00, 8'h00, 8'h00, 0, 1, 36, 1'b0);
        frame(8'hB6, 8'h00, 8'h00, 8'h00, 0, 2, 36, 1'b1);
        frame(8'h01, 8'h60, 8'h00, 8'h00, 5, 1, 41, 1'b0);
        frame(8'h00, 8'h00, 8'h00, 8'h05, 0, 0, 36, 1'b0);
        frame(8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 36, 1'b0);
        frame(8'hBB, 8'hBB, 8'hBB, 8'hBB, 0, 8, 36, 1'b0);

        repeat (3) @(negedge clk);
        chk("hold_cnt2", int'(cnt2), 3);
        chk("hold_ovf2", int'(ovf2), 1);
        chk("hold_cnt1", int'(cnt1), 8);

        frame(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 36, 1'b0);

        bus1.word_valid = 1'b1;
        bus1.word_data = 8'hBB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready", int'(bus1.word_ready), 0);
            chk("idle_busy", int'(busy1), 0);
        end
        bus1.word_valid = 1'b0;
        frame(8'h0B, 8'h00, 8'h00, 8'h00, 0, 1, 36, 1'b0);

        @(posedge clk); #1;
        start = 1'b1;
        bus1.word_valid = 1'b1;
        bus1.word_data = 8'hBB;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_ready();
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus1.word_valid = 1'b0;
        @(negedge clk);
        reset_outs("midreset");

        frame(8'hB6, 8'h00, 8'h00, 8'h00, 0, 2, 36, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb1_left", q1.size(), 0);
        chk("sb2_left", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Frame-level controller that feeds parallel words into a serial pattern detector and collects the results. It accepts words over a valid/ready handshake and serializes them MSB-first, one bit per cycle, into an overlapping Mealy pattern matcher. It counts matches across a frame of FRAME_WORDS words and reports the total with a one-cycle `done` pulse. It sits between a word-oriented producer and the detection datapath and owns all of the sequencing.

## Interface
- `WORD_W`, 8: input word width.
- `PAT_W`, 4: pattern length in bits, ≥2.
- `PATTERN`, 4'b1011: pattern to detect. The first-received bit is the MSB.
- `FRAME_WORDS`, 4: number of words per frame, ≥1.
- `CNT_W`, 8: match counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begins a frame. Honoured only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `word_valid`  in  1: producer has a word.
- `word_data`  in  WORD_W: word payload.
- `word_ready`  out  1: high only in LOAD.
- `bit_valid`  out  1: high in SHIFT.
- `bit_out`  out  1: current serialized bit.
- `match_pulse`  out  1: registered, one cycle per detected match.
- `match_count`  out  CNT_W: saturating match total for the current frame.
- `overflow`  out  1: sticky; set when a match occurs while `match_count` is all-ones.
- `done`  out  1: one-cycle pulse at frame end.

## Operation
States and transitions:
- IDLE → LOAD on `start`. The same edge clears `match_count`, `overflow`, the detector history and the word counter.
- LOAD: `word_ready`=1. On `word_valid`&`word_ready`, capture the word, set bit index to WORD_W-1, go to SHIFT. Otherwise hold.
- SHIFT: `bit_out`=word[idx], `bit_valid`=1, and the detector advances one bit. Index decrements each cycle.
  - At idx==0, if the word counter equals FRAME_WORDS-1, go to DONE.
  - Otherwise increment the word counter and go to LOAD.
- DONE: `done`=1 for one cycle, then IDLE. `match_count`/`overflow` hold until the next accepted `start`.

Detection rules:
- Detection is overlapping. A match fires on a bit when the last PAT_W accepted bits equal PATTERN, oldest bit first.
- Detector history persists across word boundaries within a frame and is cleared only on `start` or `reset`.
- A match needs at least PAT_W bits received in the frame. Cleared history must not create false matches against zeros.

Arithmetic and boundary behaviour:
- `match_count` increments by 1 per match and saturates at 2^CNT_W-1. A match at saturation sets `overflow`.
- `start` outside IDLE is ignored, including during the DONE cycle.
- `word_valid` outside LOAD is ignored and nothing is consumed.
- `reset` at any point, including mid-frame, returns to IDLE on the next edge. The partial frame is discarded.

Reset values: state IDLE. `busy`, `word_ready`, `bit_valid`, `bit_out`, `match_pulse`, `done`, `overflow` all 0. `match_count` 0.

## Timing
- `start` sampled at edge t puts LOAD (`word_ready`=1) in cycle t+1.
- A word accepted at edge e makes its MSB appear on `bit_out` in cycle e+1. Bits follow on consecutive cycles with no gaps.
- `match_pulse` and the `match_count` update appear in the cycle after the completing bit. For the final bit of a frame this is the DONE cycle, so `match_count` is final whenever `done`=1.
- Per word: 1 LOAD cycle minimum plus WORD_W SHIFT cycles. With `word_valid` held high, a frame takes FRAME_WORDS·(WORD_W+1) cycles from the first LOAD to the last SHIFT, then 1 DONE cycle.
- Producer stalls extend LOAD only. They never insert bubbles inside a word.

## Structure
- Shared package `pattern_scan_pkg`: state enum (IDLE, LOAD, SHIFT, DONE) and the default PATTERN constant.
- Sub-module `pattern_match_core`: owns the PAT_W-bit history, the fill counter and the match compare.
  - Inputs: `clk`, `reset`, `clr`, `bit_valid`, `bit_in`.
  - Output: combinational `match`.
- The controller registers `match` into `match_pulse` and the counter.

## Test plan
- Frame of 0x0B,0x00,0x00,0x00 with `word_valid` held high → one `match_pulse` on the cycle after the 8th bit. `match_count`=1 at `done`. `done` arrives 36 cycles after LOAD entry plus 1.
- Frame of 0xB6,0x00,0x00,0x00 (overlap) → 2 pulses, after bit indices 3 and 6. `match_count`=2.
- Frame of 0x01,0x60,0x00,0x00 (match spanning a word boundary) → `match_count`=1. `word_valid` deasserted for 5 cycles before word 2 → LOAD stretches by 5 cycles with no SHIFT gaps.
- Frame ending in 0x05, then a new frame starting 0x80,0x00,0x00,0x00 → second frame `match_count`=0, confirming history is cleared on `start`.
- CNT_W=2, frame of 0xBB ×4 → 8 matches. `match_count` saturates at 3, `overflow`=1. Both clear on the next `start`.
- `reset` asserted mid-SHIFT of word 2 → next cycle IDLE with all outputs at reset values. `start` pulses during SHIFT/DONE are ignored. `word_valid` in IDLE consumes nothing.
